// File: rtl/cct_result_fifo.sv
// Capture stage for the student circuit result: FWFT FIFO with ready/valid drain,
// running 16-bit sum of accepted words and a saturating drop counter.
module cct_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             sum,
  output logic [7:0]              drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              drop;
  logic              pop;

  // Status decodes depend only on registered occupancy.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready;
  assign drop = in_valid & ~in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sum      <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sum      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        sum    <= sum + 16'(in_data);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = mem[rd_ptr];
    end
  end

endmodule
